// File: rtl/lsu_rd_resp_if.sv
// Bus bundle between the LSU load port, the local buffers and the SDRAM read port.
// The master side drives the i_* signals and the slave side (lsu_rd_resp) drives the o_* signals.
interface lsu_rd_resp_if;
  logic [31:0] i_lsu_addr;
  logic        i_lsu_rden;
  logic        i_lsu_wren;
  logic [2:0]  i_lsu_funct3;
  logic [31:0] i_outbuf_rdata;
  logic [31:0] i_inbuf_rdata;
  logic        o_sdram_req;
  logic [12:0] o_sdram_addr;
  logic        i_sdram_ack;
  logic [31:0] i_sdram_rdata;
  logic [31:0] o_ld_data;
  logic        o_ld_valid;
  logic        o_ld_err;
  logic        o_lsu_stall;

  modport master (
    output i_lsu_addr, i_lsu_rden, i_lsu_wren, i_lsu_funct3,
    output i_outbuf_rdata, i_inbuf_rdata, i_sdram_ack, i_sdram_rdata,
    input  o_sdram_req, o_sdram_addr, o_ld_data, o_ld_valid, o_ld_err, o_lsu_stall
  );

  modport slave (
    input  i_lsu_addr, i_lsu_rden, i_lsu_wren, i_lsu_funct3,
    input  i_outbuf_rdata, i_inbuf_rdata, i_sdram_ack, i_sdram_rdata,
    output o_sdram_req, o_sdram_addr, o_ld_data, o_ld_valid, o_ld_err, o_lsu_stall
  );
endinterface

// File: rtl/lsu_rd_resp.sv
// Load response unit: decodes the load address, reads OUTBUF/INBUF directly or SDRAM via req/ack,
// and formats the result. Define LSU_RD_TIMEOUT_EN to abandon SDRAM reads after 255 cycles.
module lsu_rd_resp (
  input  logic           i_clk,
  input  logic           i_reset,
  lsu_rd_resp_if.slave   bus
);

  typedef enum logic [1:0] {IDLE, SD_REQ, RESP} state_t;

  state_t      state, state_nxt;
  logic [1:0]  addr_lo;
  logic [2:0]  funct3;
  logic [31:0] ld_data;
  logic        ld_err;
  logic [12:0] sdram_addr;
  logic        req_take;
  logic        misal;
  logic        sdram_hit;
  logic        outbuf_hit;
  logic        inbuf_hit;
  logic        tmo_hit;
  logic        unused_bits;

  function automatic logic misaligned(input logic [2:0] f3, input logic [1:0] a);
    case (f3)
      3'b000, 3'b100: return 1'b0;
      3'b001, 3'b101: return a[0];
      default:        return (a != 2'b00);
    endcase
  endfunction

  function automatic logic [31:0] fmt(input logic [31:0] w, input logic [1:0] a,
                                      input logic [2:0] f3);
    logic [7:0]  b;
    logic [15:0] h;
    b = w[{a, 3'b000} +: 8];
    h = a[1] ? w[31:16] : w[15:0];
    case (f3)
      3'b000:  return {{24{b[7]}}, b};
      3'b100:  return {24'h000000, b};
      3'b001:  return {{16{h[15]}}, h};
      3'b101:  return {16'h0000, h};
      default: return w;
    endcase
  endfunction

  assign unused_bits = ^bus.i_lsu_addr[31:16];

  assign sdram_hit  = (bus.i_lsu_addr[15:13] == 3'b001);
  assign outbuf_hit = (bus.i_lsu_addr[15:8] == 8'h70);
  assign inbuf_hit  = (bus.i_lsu_addr[15:8] == 8'h78);
  assign misal      = misaligned(bus.i_lsu_funct3, bus.i_lsu_addr[1:0]);
  assign req_take   = (state == IDLE) && bus.i_lsu_rden && !bus.i_lsu_wren;

`ifdef LSU_RD_TIMEOUT_EN
  logic [7:0] tmo_cnt;
  // Counter reads 254 during the 255th SD_REQ cycle; expiring there puts RESP in cycle 256.
  assign tmo_hit = (tmo_cnt == 8'd254);
`else
  assign tmo_hit = 1'b0;
`endif

  always_ff @(posedge i_clk or posedge i_reset) begin
    if (i_reset) state <= IDLE;
    else         state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (req_take) state_nxt = (sdram_hit && !misal) ? SD_REQ : RESP;
      SD_REQ:  if (bus.i_sdram_ack || tmo_hit) state_nxt = RESP;
      RESP:    state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  // Request edge captures fast-path data; SDRAM path captures on ack (or timeout)
  always_ff @(posedge i_clk or posedge i_reset) begin
    if (i_reset) begin
      addr_lo    <= 2'b00;
      funct3     <= 3'b000;
      ld_data    <= 32'h0;
      ld_err     <= 1'b0;
      sdram_addr <= 13'h0;
`ifdef LSU_RD_TIMEOUT_EN
      tmo_cnt    <= 8'h00;
`endif
    end else begin
      case (state)
        IDLE: begin
          if (req_take) begin
            addr_lo <= bus.i_lsu_addr[1:0];
            funct3  <= bus.i_lsu_funct3;
            ld_err  <= 1'b0;
            if (misal) begin
              ld_data <= 32'h0;
              ld_err  <= 1'b1;
            end else if (sdram_hit) begin
              sdram_addr <= {bus.i_lsu_addr[12:2], 2'b00};
`ifdef LSU_RD_TIMEOUT_EN
              tmo_cnt    <= 8'h00;
`endif
            end else if (outbuf_hit) begin
              ld_data <= fmt(bus.i_outbuf_rdata, bus.i_lsu_addr[1:0], bus.i_lsu_funct3);
            end else if (inbuf_hit) begin
              ld_data <= fmt(bus.i_inbuf_rdata, bus.i_lsu_addr[1:0], bus.i_lsu_funct3);
            end else begin
              ld_data <= 32'h0;
            end
          end
        end
        SD_REQ: begin
`ifdef LSU_RD_TIMEOUT_EN
          tmo_cnt <= tmo_cnt + 8'd1;
`endif
          if (bus.i_sdram_ack) begin
            ld_data <= fmt(bus.i_sdram_rdata, addr_lo, funct3);
            ld_err  <= 1'b0;
          end else if (tmo_hit) begin
            ld_data <= 32'hDEADBEEF;
            ld_err  <= 1'b1;
          end
        end
        default: ;
      endcase
    end
  end

  assign bus.o_sdram_req  = (state == SD_REQ);
  assign bus.o_sdram_addr = sdram_addr;
  assign bus.o_ld_data    = ld_data;
  assign bus.o_ld_valid   = (state == RESP);
  assign bus.o_ld_err     = (state == RESP) && ld_err;
  assign bus.o_lsu_stall  = (state != IDLE);

endmodule

// File: tb/tb_lsu_rd_resp.sv
// Directed bench for lsu_rd_resp: fast paths, SDRAM handshake, formatting, misalignment,
// reset abandon and (with LSU_RD_TIMEOUT_EN) the SDRAM timeout.
module tb_lsu_rd_resp;

  logic clk;
  logic rst;
  int   n_tests;
  int   n_fail;

  lsu_rd_resp_if bus ();

  lsu_rd_resp dut (
    .i_clk   (clk),
    .i_reset (rst),
    .bus     (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog got=timeout exp=finish");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  task automatic fast_load(input string tag, input logic [31:0] addr, input logic [2:0] f3,
                           input logic [31:0] ob, input logic [31:0] ib,
                           input logic [31:0] exp_d, input logic exp_e);
    @(negedge clk);
    bus.i_lsu_addr     = addr;
    bus.i_lsu_funct3   = f3;
    bus.i_outbuf_rdata = ob;
    bus.i_inbuf_rdata  = ib;
    bus.i_lsu_rden     = 1'b1;
    chk({tag, "_stall_pre"}, 32'(bus.o_lsu_stall), 32'd0);
    @(negedge clk);
    chk({tag, "_valid"}, 32'(bus.o_ld_valid), 32'd1);
    chk({tag, "_data"},  bus.o_ld_data, exp_d);
    chk({tag, "_err"},   32'(bus.o_ld_err), 32'(exp_e));
    chk({tag, "_stall"}, 32'(bus.o_lsu_stall), 32'd1);
    chk({tag, "_noreq"}, 32'(bus.o_sdram_req), 32'd0);
    bus.i_lsu_rden = 1'b0;
    @(negedge clk);
    chk({tag, "_valid_end"}, 32'(bus.o_ld_valid), 32'd0);
    chk({tag, "_stall_end"}, 32'(bus.o_lsu_stall), 32'd0);
  endtask

  task automatic sd_load(input string tag, input logic [31:0] addr, input logic [2:0] f3,
                         input int n_wait, input logic [31:0] rdata, input logic [12:0] exp_a,
                         input logic [31:0] exp_d, input logic hold);
    @(negedge clk);
    bus.i_lsu_addr   = addr;
    bus.i_lsu_funct3 = f3;
    bus.i_lsu_rden   = 1'b1;
    for (int i = 0; i < n_wait; i++) begin
      @(negedge clk);
      chk($sformatf("%s_req%0d", tag, i), 32'(bus.o_sdram_req), 32'd1);
      if (i == 0) chk({tag, "_addr"}, 32'(bus.o_sdram_addr), 32'(exp_a));
      if (!hold) bus.i_lsu_rden = 1'b0;
      if (i == n_wait - 1) begin
        bus.i_sdram_ack   = 1'b1;
        bus.i_sdram_rdata = rdata;
      end
    end
    @(negedge clk);
    bus.i_sdram_ack = 1'b0;
    bus.i_lsu_rden  = 1'b0;
    chk({tag, "_req_drop"}, 32'(bus.o_sdram_req), 32'd0);
    chk({tag, "_valid"},    32'(bus.o_ld_valid), 32'd1);
    chk({tag, "_data"},     bus.o_ld_data, exp_d);
    chk({tag, "_err"},      32'(bus.o_ld_err), 32'd0);
    @(negedge clk);
    chk({tag, "_valid_end"}, 32'(bus.o_ld_valid), 32'd0);
    chk({tag, "_stall_end"}, 32'(bus.o_lsu_stall), 32'd0);
  endtask

  initial begin
    int  cyc;
    logic seen;
    n_tests = 0;
    n_fail  = 0;
    rst = 1'b1;
    bus.i_lsu_addr     = 32'h0;
    bus.i_lsu_rden     = 1'b0;
    bus.i_lsu_wren     = 1'b0;
    bus.i_lsu_funct3   = 3'b000;
    bus.i_outbuf_rdata = 32'h0;
    bus.i_inbuf_rdata  = 32'h0;
    bus.i_sdram_ack    = 1'b0;
    bus.i_sdram_rdata  = 32'h0;
    repeat (2) @(negedge clk);
    chk("rst_req",   32'(bus.o_sdram_req),  32'd0);
    chk("rst_valid", 32'(bus.o_ld_valid),   32'd0);
    chk("rst_err",   32'(bus.o_ld_err),     32'd0);
    chk("rst_stall", 32'(bus.o_lsu_stall),  32'd0);
    chk("rst_data",  bus.o_ld_data,         32'd0);
    chk("rst_addr",  32'(bus.o_sdram_addr), 32'd0);
    rst = 1'b0;

    fast_load("lw_inbuf",  32'h0000_7800, 3'b010, 32'h0, 32'h1234_5678, 32'h1234_5678, 1'b0);
    fast_load("lhu_obuf",  32'h0000_7002, 3'b101, 32'hBEEF_0000, 32'h0, 32'h0000_BEEF, 1'b0);
    fast_load("lh_obuf",   32'hFFFF_7000, 3'b001, 32'h0000_8001, 32'h0, 32'hFFFF_8001, 1'b0);
    fast_load("lbu_ibuf",  32'h0000_7801, 3'b100, 32'h0, 32'h0000_A500, 32'h0000_00A5, 1'b0);
    fast_load("lb_obuf",   32'h0000_7001, 3'b000, 32'h0000_7F00, 32'h0, 32'h0000_007F, 1'b0);
    fast_load("f3_011_lw", 32'h0000_7804, 3'b011, 32'h0, 32'hCAFE_F00D, 32'hCAFE_F00D, 1'b0);
    fast_load("lw_unmap",  32'h0000_4000, 3'b010, 32'h1111_1111, 32'h2222_2222, 32'h0, 1'b0);
    fast_load("lw_misal",  32'h0000_2001, 3'b010, 32'h0, 32'h0, 32'h0, 1'b1);
    fast_load("lh_misal",  32'h0000_7801, 3'b001, 32'h0, 32'hFFFF_FFFF, 32'h0, 1'b1);

    sd_load("lb_sd",  32'h0000_2003, 3'b000, 3, 32'h80FF_FFFF, 13'h0000, 32'hFFFF_FF80, 1'b0);
    sd_load("lhu_sd", 32'h0000_2006, 3'b101, 1, 32'hABCD_1234, 13'h0004, 32'h0000_ABCD, 1'b1);

    // store in progress: rden must be ignored
    @(negedge clk);
    bus.i_lsu_addr   = 32'h0000_7800;
    bus.i_lsu_funct3 = 3'b010;
    bus.i_lsu_rden   = 1'b1;
    bus.i_lsu_wren   = 1'b1;
    @(negedge clk);
    chk("wren_stall", 32'(bus.o_lsu_stall), 32'd0);
    chk("wren_valid", 32'(bus.o_ld_valid),  32'd0);
    bus.i_lsu_rden = 1'b0;
    bus.i_lsu_wren = 1'b0;

    // ack while idle must be ignored
    bus.i_sdram_ack = 1'b1;
    @(negedge clk);
    bus.i_sdram_ack = 1'b0;
    chk("idle_ack_valid", 32'(bus.o_ld_valid),  32'd0);
    chk("idle_ack_stall", 32'(bus.o_lsu_stall), 32'd0);

    // reset in SD_REQ abandons the request
    @(negedge clk);
    bus.i_lsu_addr   = 32'h0000_2004;
    bus.i_lsu_funct3 = 3'b010;
    bus.i_lsu_rden   = 1'b1;
    @(negedge clk);
    chk("rstsd_req_before", 32'(bus.o_sdram_req), 32'd1);
    bus.i_lsu_rden = 1'b0;
    #2 rst = 1'b1;
    #1;
    chk("rstsd_req_now",   32'(bus.o_sdram_req), 32'd0);
    chk("rstsd_stall_now", 32'(bus.o_lsu_stall), 32'd0);
    @(negedge clk);
    rst = 1'b0;
    bus.i_sdram_ack   = 1'b1;
    bus.i_sdram_rdata = 32'h5555_AAAA;
    seen = 1'b0;
    repeat (3) begin
      @(negedge clk);
      bus.i_sdram_ack = 1'b0;
      if (bus.o_ld_valid) seen = 1'b1;
    end
    chk("rstsd_no_valid", 32'(seen), 32'd0);

`ifdef LSU_RD_TIMEOUT_EN
    @(negedge clk);
    bus.i_lsu_addr   = 32'h0000_2000;
    bus.i_lsu_funct3 = 3'b010;
    bus.i_lsu_rden   = 1'b1;
    cyc = 0;
    while (cyc < 400) begin
      @(negedge clk);
      bus.i_lsu_rden = 1'b0;
      cyc++;
      if (bus.o_ld_valid) break;
    end
    chk("tmo_cycle", 32'(cyc), 32'd256);
    chk("tmo_data",  bus.o_ld_data, 32'hDEAD_BEEF);
    chk("tmo_err",   32'(bus.o_ld_err), 32'd1);
    @(negedge clk);
    bus.i_sdram_ack = 1'b1;
    @(negedge clk);
    bus.i_sdram_ack = 1'b0;
    chk("tmo_late_ack_valid", 32'(bus.o_ld_valid),  32'd0);
    chk("tmo_late_ack_stall", 32'(bus.o_lsu_stall), 32'd0);
`else
    @(negedge clk);
    bus.i_lsu_addr   = 32'h0000_3FFC;
    bus.i_lsu_funct3 = 3'b010;
    bus.i_lsu_rden   = 1'b1;
    cyc = 0;
    repeat (300) begin
      @(negedge clk);
      bus.i_lsu_rden = 1'b0;
      if (bus.o_ld_valid) cyc++;
    end
    chk("wait_no_valid", 32'(cyc), 32'd0);
    chk("wait_req_held", 32'(bus.o_sdram_req), 32'd1);
    chk("wait_addr",     32'(bus.o_sdram_addr), 32'h1FFC);
    bus.i_sdram_ack   = 1'b1;
    bus.i_sdram_rdata = 32'h1122_3344;
    @(negedge clk);
    bus.i_sdram_ack = 1'b0;
    chk("wait_valid", 32'(bus.o_ld_valid), 32'd1);
    chk("wait_data",  bus.o_ld_data, 32'h1122_3344);
`endif

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/lsu_rd_resp.md
LSU_RD_RESP -- requirements
Module: lsu_rd_resp

Interface
REQ-001 SHALL have one clock and an asynchronous, active-high reset.
REQ-002 i_clk  in  1  sole clock; all state on rising edge.
REQ-003 i_reset  in  1  asynchronous, active-high reset.
REQ-004 i_lsu_addr  in  32  load address; only [15:0] decoded, [31:16] ignored.
REQ-005 i_lsu_rden  in  1  load request, sampled only in IDLE.
REQ-006 i_lsu_wren  in  1  store in progress; when high, i_lsu_rden is ignored.
REQ-007 i_lsu_funct3  in  3  load type: 000 LB, 001 LH, 010 LW, 100 LBU, 101 LHU; others are treated as LW.
REQ-008 i_outbuf_rdata  in  32  output-buffer readback word, combinational.
REQ-009 i_inbuf_rdata  in  32  input-buffer word, combinational.
REQ-010 o_sdram_req  out  1  SDRAM read request, held until ack.
REQ-011 o_sdram_addr  out  13  word-aligned SDRAM offset, {addr[12:2],2'b00}, held stable while o_sdram_req is high.
REQ-012 i_sdram_ack  in  1  one-cycle ack; i_sdram_rdata is valid in the same cycle.
REQ-013 i_sdram_rdata  in  32  SDRAM read word.
REQ-014 o_ld_data  out  32  formatted load result.
REQ-015 o_ld_valid  out  1  one-cycle result strobe.
REQ-016 o_ld_err  out  1  error flag, qualified by o_ld_valid.
REQ-017 o_lsu_stall  out  1  high while the block is busy.

Function
REQ-018 Decode SHALL be: SDRAM addr[15:13]=001 (0x2000-0x3FFF); OUTBUF addr[15:8]=0x70; INBUF addr[15:8]=0x78; all other addresses are UNMAPPED.
REQ-019 The FSM SHALL have three states: IDLE, SD_REQ and RESP.
REQ-020 IDLE: when rden=1 and wren=0, the block SHALL latch addr[1:0] and funct3, go to SD_REQ for SDRAM, otherwise go to RESP.
REQ-021 Fast paths (OUTBUF, INBUF) SHALL register the source word on the request edge, with o_ld_valid high in the next cycle (latency 1).
REQ-022 UNMAPPED accesses SHALL return 0x00000000 with o_ld_err=0 and latency 1.
REQ-023 SD_REQ: o_sdram_req SHALL be high; when ack=1, rdata is latched and the FSM moves to RESP; response latency is ack cycle +1.
REQ-024 RESP SHALL last exactly one cycle, with o_ld_valid=1, and then return to IDLE.
REQ-025 o_lsu_stall SHALL be 1 in SD_REQ and RESP, and 0 in IDLE.
REQ-026 Formatting SHALL work as follows: the byte is selected by addr[1:0], the half by addr[1]. LB/LH sign-extend; LBU/LHU zero-extend.
REQ-027 Misaligned accesses (LH/LHU with addr[0]=1, or LW with addr[1:0]!=0) SHALL return data 0 with o_ld_err=1 at latency 1, with no SDRAM request issued, whatever the region.
REQ-028 An ack outside SD_REQ SHALL be ignored.
REQ-029 A new rden during SD_REQ or RESP SHALL be ignored; the requester holds the request until stall is low.

Reset
REQ-030 On reset the block SHALL enter IDLE, and o_sdram_req, o_ld_valid, o_ld_err, o_lsu_stall, o_ld_data and o_sdram_addr SHALL all be 0.
REQ-031 A reset asserted in SD_REQ SHALL drop o_sdram_req immediately, abandon the outstanding request, and produce no o_ld_valid.

Configuration
REQ-032 LSU_RD_TIMEOUT_EN defined: an 8-bit counter SHALL clear on entry to SD_REQ and increment each SD_REQ cycle. After 255 cycles with no ack, the FSM goes to RESP with data 0xDEADBEEF and o_ld_err=1. A late ack is then ignored.
REQ-033 LSU_RD_TIMEOUT_EN undefined: no counter SHALL exist, and SD_REQ waits indefinitely for ack.

Verification
REQ-034 LW 0x7800 with inbuf=0x12345678 -> next cycle valid=1, data 0x12345678, err=0, stall high for 1 cycle.
REQ-035 LB 0x2003, ack after 3 cycles with rdata=0x80FFFFFF -> o_sdram_addr 0x0000, req high for 3 cycles, then data 0xFFFFFF80 one cycle after ack.
REQ-036 LHU 0x7002 with outbuf=0xBEEF0000 -> data 0x0000BEEF; LW 0x2001 -> err=1, data 0, req never asserted.
REQ-037 rden=1 with wren=1 -> no state change; LW 0x4000 -> data 0, err=0.
REQ-038 Reset pulse while in SD_REQ -> req=0 at once, no valid; with LSU_RD_TIMEOUT_EN, no ack -> valid at cycle 256 with 0xDEADBEEF and err=1.
